// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: prescaled digit scan with a guard-blanked slot
// start, leading-zero suppression and a double-buffered value updated only between frames.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD       = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Load,
    input  logic                    i_Enable,
    input  logic                    i_Blank_Lead,
    output logic [6:0]              o_Segment,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        r_Cnt;
    logic [IDX_W-1:0]        r_Idx;
    logic [4*NUM_DIGITS-1:0] r_Pend;
    logic                    r_Pend_Valid;
    logic [4*NUM_DIGITS-1:0] r_Buf;

    logic                  w_Boundary;
    logic [3:0]            w_Nib;
    logic                  w_Zero;
    logic                  w_Blank;
    logic                  w_On;
    logic [NUM_DIGITS-1:0] w_Dig;
    logic [6:0]            w_Seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h7E;
            4'h1: seg_decode = 7'h30;
            4'h2: seg_decode = 7'h6D;
            4'h3: seg_decode = 7'h79;
            4'h4: seg_decode = 7'h33;
            4'h5: seg_decode = 7'h5B;
            4'h6: seg_decode = 7'h5F;
            4'h7: seg_decode = 7'h70;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h7B;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h1F;
            4'hC: seg_decode = 7'h4E;
            4'hD: seg_decode = 7'h3D;
            4'hE: seg_decode = 7'h4F;
            default: seg_decode = 7'h47;
        endcase
    endfunction

    assign w_Boundary = (r_Cnt == CNT_MAX) && (r_Idx == IDX_MAX);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Cnt <= '0;
            r_Idx <= '0;
        end else if (r_Cnt == CNT_MAX) begin
            r_Cnt <= '0;
            r_Idx <= (r_Idx == IDX_MAX) ? '0 : r_Idx + 1'b1;
        end else begin
            r_Cnt <= r_Cnt + 1'b1;
        end
    end

    // A load landing on the boundary still hands over the older pending value first.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Pend       <= '0;
            r_Pend_Valid <= 1'b0;
            r_Buf        <= '0;
        end else begin
            if (w_Boundary && r_Pend_Valid) begin
                r_Buf <= r_Pend;
            end
            if (i_Load) begin
                r_Pend       <= i_Value;
                r_Pend_Valid <= 1'b1;
            end else if (w_Boundary) begin
                r_Pend_Valid <= 1'b0;
            end
        end
    end

    // Walking down from the top digit, w_Zero means "this digit and all above are zero".
    always_comb begin
        w_Nib   = 4'h0;
        w_Zero  = 1'b1;
        w_Blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_Zero = w_Zero && (r_Buf[4*k +: 4] == 4'h0);
            if (r_Idx == IDX_W'(k)) begin
                w_Nib   = r_Buf[4*k +: 4];
                w_Blank = i_Blank_Lead && (k != 0) && w_Zero;
            end
        end
    end

    always_comb begin
        w_On = i_Enable && (r_Cnt >= GUARD_C) && !w_Blank;
        w_Dig = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_Dig[k] = w_On && (r_Idx == IDX_W'(k));
        end
        w_Seg = w_On ? seg_decode(w_Nib) : 7'h00;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Segment    <= SEG_OFF;
            o_Digit_En   <= DIG_OFF;
            o_Frame_Done <= 1'b0;
        end else begin
            o_Segment    <= (ACTIVE_LOW != 0) ? ~w_Seg : w_Seg;
            o_Digit_En   <= (ACTIVE_LOW != 0) ? ~w_Dig : w_Dig;
            o_Frame_Done <= w_Boundary;
        end
    end

endmodule
